// File: rtl/seq_stream_gen_if.sv
// Pattern-transmitter bus: start/configuration inputs and the serial stream
// with its status outputs.
interface seq_stream_gen_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP_W = 3
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             serial_out;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic [1:0]       current;

  // Drives requests, observes the stream.
  modport master (
    output start, pattern, reps, gap,
    input  serial_out, bit_valid, busy, done, current
  );

  // The transmitter itself.
  modport slave (
    input  start, pattern, reps, gap,
    output serial_out, bit_valid, busy, done, current
  );
endinterface

// File: rtl/seq_stream_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated
// reps times with gap idle cycles between repetitions. All stream outputs are
// registered; busy/current come straight from the state register.
module seq_stream_gen #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP_W = 3
) (
  input logic clk,
  input logic rst,
  seq_stream_gen_if.slave bus
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StSend = 2'b01,
    StGap  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] reps_left_q, reps_left_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_left_q, gap_left_d;
  logic             serial_out_q, serial_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             done_q, done_d;

  // Next-state logic; output flops are loaded with the value for the next cycle.
  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    idx_d        = idx_q;
    reps_left_d  = reps_left_q;
    gap_d        = gap_q;
    gap_left_d   = gap_left_q;
    serial_out_d = 1'b0;
    bit_valid_d  = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start && (bus.reps != '0)) begin
          state_d      = StSend;
          pat_d        = bus.pattern;
          reps_left_d  = bus.reps;
          gap_d        = bus.gap;
          idx_d        = IDX_W'(PAT_W - 1);
          serial_out_d = bus.pattern[PAT_W-1];
          bit_valid_d  = 1'b1;
        end
      end

      StSend: begin
        if (idx_q != '0) begin
          idx_d        = idx_q - 1'b1;
          serial_out_d = pat_q[idx_q - 1'b1];
          bit_valid_d  = 1'b1;
        end else if (reps_left_q > CNT_W'(1)) begin
          reps_left_d = reps_left_q - 1'b1;
          idx_d       = IDX_W'(PAT_W - 1);
          if (gap_q != '0) begin
            state_d    = StGap;
            gap_left_d = gap_q;
          end else begin
            // Zero gap: next repetition's MSB follows with no bubble.
            serial_out_d = pat_q[PAT_W-1];
            bit_valid_d  = 1'b1;
          end
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      StGap: begin
        // gap_left_q counts the gap cycles still to show, including this one.
        if (gap_left_q <= GAP_W'(1)) begin
          state_d      = StSend;
          gap_left_d   = '0;
          serial_out_d = pat_q[idx_q];
          bit_valid_d  = 1'b1;
        end else begin
          gap_left_d = gap_left_q - 1'b1;
        end
      end

      default: begin
        // Illegal encoding: recover to a clean idle.
        state_d     = StIdle;
        pat_d       = '0;
        idx_d       = '0;
        reps_left_d = '0;
        gap_d       = '0;
        gap_left_d  = '0;
      end
    endcase
  end

  // State, latches, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      pat_q        <= '0;
      idx_q        <= '0;
      reps_left_q  <= '0;
      gap_q        <= '0;
      gap_left_q   <= '0;
      serial_out_q <= 1'b0;
      bit_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      idx_q        <= idx_d;
      reps_left_q  <= reps_left_d;
      gap_q        <= gap_d;
      gap_left_q   <= gap_left_d;
      serial_out_q <= serial_out_d;
      bit_valid_q  <= bit_valid_d;
      done_q       <= done_d;
    end
  end

  assign bus.serial_out = serial_out_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.current    = state_q;

endmodule

// File: tb/tb_seq_stream_gen.sv
// Directed plus randomized bench for seq_stream_gen against a per-cycle
// expected-stream model built from the transmission rules.
module tb_seq_stream_gen;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned GAP_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  seq_stream_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  seq_stream_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       s;
    logic       v;
    logic       b;
    logic       d;
    logic [1:0] cur;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".serial_out"}, 32'(bus.serial_out), 32'(e.s));
    chk({tag, ".bit_valid"},  32'(bus.bit_valid),  32'(e.v));
    chk({tag, ".busy"},       32'(bus.busy),       32'(e.b));
    chk({tag, ".done"},       32'(bus.done),       32'(e.d));
    chk({tag, ".current"},    32'(bus.current),    32'(e.cur));
  endtask

  // Expect idle outputs for n cycles with start low.
  task automatic idle_cycles(input string tag, input int n);
    exp_t e;
    e = '0;
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_all(tag, e);
    end
  endtask

  // Starts a transmission at the current negedge, then checks every cycle up
  // to and including the done cycle. Inputs are scrambled while busy; if
  // intrude matches a cycle number, start is pulsed with an all-zero pattern.
  // Returns at the negedge of the done cycle with start low.
  task automatic tx(input string tag, input logic [PAT_W-1:0] pat,
                    input logic [CNT_W-1:0] reps, input logic [GAP_W-1:0] gap,
                    input int intrude);
    exp_t q[$];
    exp_t e;
    q = {};
    for (int r = 0; r < int'(reps); r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        e = '{s: pat[b], v: 1'b1, b: 1'b1, d: 1'b0, cur: 2'b01};
        q.push_back(e);
      end
      if (r < int'(reps) - 1) begin
        for (int g = 0; g < int'(gap); g++) begin
          e = '{s: 1'b0, v: 1'b0, b: 1'b1, d: 1'b0, cur: 2'b10};
          q.push_back(e);
        end
      end
    end
    e = '{s: 1'b0, v: 1'b0, b: 1'b0, d: 1'b1, cur: 2'b00};
    q.push_back(e);

    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.reps    = reps;
    bus.gap     = gap;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      chk_all(tag, q[i]);
      bus.start   = (i + 1 == intrude);
      bus.pattern = (i + 1 == intrude) ? '0 : PAT_W'($urandom);
      bus.reps    = CNT_W'($urandom_range(1, 15));
      bus.gap     = GAP_W'($urandom);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    exp_t z;
    z = '0;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.reps    = '0;
    bus.gap     = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk_all("reset", z);
    rst = 1'b1;
    idle_cycles("post_reset", 2);

    // Directed cases.
    tx("single", 4'b1011, 4'd1, 3'd0, -1);
    idle_cycles("after_single", 1);
    tx("rep3_nogap", 4'b1011, 4'd3, 3'd0, -1);
    idle_cycles("after_rep3", 1);
    tx("rep2_gap2", 4'b1011, 4'd2, 3'd2, -1);
    idle_cycles("after_gap2", 1);

    // reps == 0 request is ignored.
    bus.start   = 1'b1;
    bus.pattern = 4'b1111;
    bus.reps    = '0;
    bus.gap     = 3'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_all("reps_zero", z);
    end
    bus.start = 1'b0;

    // start during transmission is ignored.
    tx("intrude", 4'b1011, 4'd2, 3'd0, 3);
    idle_cycles("after_intrude", 1);

    // Back-to-back: next start in the done cycle.
    tx("b2b_a", 4'b1001, 4'd1, 3'd3, -1);
    tx("b2b_b", 4'b0110, 4'd2, 3'd1, -1);
    tx("b2b_c", 4'b1110, 4'd2, 3'd7, -1);
    idle_cycles("after_b2b", 1);

    // Asynchronous reset mid-SEND.
    bus.start   = 1'b1;
    bus.pattern = 4'b1011;
    bus.reps    = 4'd2;
    bus.gap     = 3'd0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rst_mid.bit1", 32'(bus.serial_out), 32'd1);
    @(negedge clk);
    chk("rst_mid.bit2", 32'(bus.serial_out), 32'd0);
    #2 rst = 1'b0;
    #1 chk_all("rst_mid.async", z);
    @(negedge clk);
    chk_all("rst_mid.held", z);
    rst = 1'b1;
    idle_cycles("rst_mid.released", 2);
    tx("after_rst", 4'b0101, 4'd2, 3'd1, -1);
    idle_cycles("after_rst_idle", 1);

    // Randomized transmissions, some chained, some with intruding starts.
    for (int n = 0; n < 12; n++) begin
      tx("rand", PAT_W'($urandom), CNT_W'($urandom_range(1, 4)),
         GAP_W'($urandom_range(0, 3)),
         ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : -1);
      if ($urandom_range(0, 2) == 0) idle_cycles("rand_idle", 1);
    end
    idle_cycles("final_idle", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_stream_gen.md
Name: seq_stream_gen

Overview:
- Serial pattern transmitter: the driving end of the sequence-detector interface.
- Serializes a loaded PAT_W-bit pattern MSB-first onto a 1-bit stream, repeated a programmable number of times, with a programmable idle gap between repetitions.
- Used as the stimulus source feeding a sequence detector's serial input; exposes its FSM state for assertion binding.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
CNT_W, 4, width of repetition count
GAP_W, 3, width of inter-repetition gap count

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
start  input  1  request to begin a transmission; sampled only in IDLE
pattern  input  PAT_W  bits to send, MSB first; latched on accepted start
reps  input  CNT_W  number of repetitions; latched on accepted start
gap  input  GAP_W  idle cycles between repetitions; latched on accepted start
serial_out  output  1  transmitted bit; 0 when not in SEND
bit_valid  output  1  high exactly in cycles where serial_out carries a pattern bit
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse after final bit of final repetition
current  output  2  FSM state: IDLE=2'b00, SEND=2'b01, GAP=2'b10

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, serial_out=0, bit_valid=0, busy=0, done=0, all internal counters and latches cleared. Takes effect immediately, including mid-transmission; a partial stream is abandoned with no done pulse.
- All outputs are registered. No output is ever X after reset.
- IDLE:
  - start=1 and reps!=0 at a rising edge: accept. Latch pattern/reps/gap, bit index=PAT_W-1, reps remaining=reps; go to SEND.
  - start=1 with reps==0: ignored; stay IDLE, no done.
- SEND:
  - Each cycle drives serial_out=latched pattern[bit index], bit_valid=1.
  - The first bit is visible in the cycle immediately after the start edge. Latency start->first bit = 1 cycle.
  - Bit index decrements each cycle.
  - After bit 0 with reps remaining>1: decrement reps remaining and reload index to PAT_W-1. If gap!=0, go to GAP; if gap==0, stay in SEND and drive the next repetition's MSB on the next cycle with no bubble.
  - After bit 0 with reps remaining==1: go to IDLE and pulse done=1 for exactly one cycle, the cycle after the last bit, concurrent with busy=0.
- GAP:
  - Drive serial_out=0, bit_valid=0 for exactly gap cycles (counter loaded with latched gap), then go to SEND.
- Inputs during transmission:
  - start while busy=1 is ignored.
  - Changes to pattern/reps/gap while busy=1 have no effect.
- Back-to-back transmissions: start may be asserted in the same cycle done is high (state is IDLE). It is accepted, and the first bit follows one cycle later.
- current=2'b11 is unreachable. If entered (e.g. via fault injection), the next state is IDLE with outputs cleared.
- Total stream length (SEND cycles) = PAT_W*reps.
- Busy duration = PAT_W*reps + gap*(reps-1) cycles.

Test Plan:
- pattern=4'b1011, reps=1, gap=0, start at cycle 0 -> serial_out 1,0,1,1 with bit_valid=1 in cycles 1-4; done=1 and busy=0 in cycle 5 only.
- pattern=4'b1011, reps=3, gap=0 -> contiguous 12-bit stream 101110111011 in cycles 1-12, bit_valid never drops; single done in cycle 13.
- pattern=4'b1011, reps=2, gap=2 -> cycles 1-4: 1011; cycles 5-6: serial_out=0, bit_valid=0, current=2'b10; cycles 7-10: 1011; done in cycle 11.
- start with reps=0 -> busy, bit_valid and done stay 0 for 10 cycles; current=2'b00.
- Transmission of reps=2 in progress: pulse start with pattern=4'b0000 at cycle 3 -> ignored; stream stays 10111011; done asserted once.
- rst driven low at cycle 2 (mid-SEND, between clock edges) -> all outputs 0 and current=2'b00 immediately; no done. After release, a new start transmits normally.
